// File: rtl/tmr_sram_scrub.sv
// Triple-modular-redundant SRAM with majority-vote reads, write-back
// correction of single-bank faults and a background scrubber.
module tmr_sram_scrub #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned SCRUB_EN       = 1,
  parameter int unsigned SCRUB_INTERVAL = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              err_single,
  output logic              err_multi,
  output logic [ADDR_W-1:0] err_addr,
  output logic              scrub_busy,
  output logic [CNT_W-1:0]  corr_count,
  input  logic              clr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned TMR_W = $clog2(SCRUB_INTERVAL);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, RD_CHK, SCRUB_RD, SCRUB_CHK, FIX} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];

  logic [DATA_W-1:0] rd0, rd1, rd2, vote;
  logic [ADDR_W-1:0] lat_addr, scrub_ptr;
  logic [TMR_W-1:0]  timer;
  logic              pend;
  logic              accept, user_rd, scrub_due, scrub_start, chk;
  logic              eq01, eq02, eq12, all_eq, one_off, none_eq;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign ready      = rst && (state == IDLE);
  assign accept     = ready && enable;
  assign scrub_busy = (state == SCRUB_RD) || (state == SCRUB_CHK);

  // Bitwise majority and agreement classification of the three latched words
  always_comb begin
    vote    = (rd0 & rd1) | (rd0 & rd2) | (rd1 & rd2);
    eq01    = (rd0 == rd1);
    eq02    = (rd0 == rd2);
    eq12    = (rd1 == rd2);
    all_eq  = eq01 && eq12;
    none_eq = !eq01 && !eq02 && !eq12;
    one_off = !all_eq && !none_eq;
  end

  // Next-state selection and bank write-port steering
  always_comb begin
    state_nxt   = state;
    user_rd     = 1'b0;
    scrub_due   = (SCRUB_EN != 0) && (pend || (timer == TMR_LAST));
    scrub_start = 1'b0;
    chk         = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = addr;
    mem_wdata   = data_in;
    case (state)
      IDLE: begin
        if (accept) begin
          mem_we  = we;
          user_rd = !we;
          if (!we) state_nxt = RD_CHK;
        end else if (rst && scrub_due) begin
          scrub_start = 1'b1;
          state_nxt   = SCRUB_RD;
        end
      end
      RD_CHK, SCRUB_CHK: begin
        chk       = 1'b1;
        state_nxt = one_off ? FIX : IDLE;
      end
      SCRUB_RD: state_nxt = SCRUB_CHK;
      FIX: begin
        mem_we    = 1'b1;
        mem_waddr = lat_addr;
        mem_wdata = vote;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Bank storage: common write to all banks, synchronous read into vote latches
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem0[mem_waddr] <= mem_wdata;
      mem1[mem_waddr] <= mem_wdata;
      mem2[mem_waddr] <= mem_wdata;
    end
    if (user_rd) begin
      rd0 <= mem0[addr];
      rd1 <= mem1[addr];
      rd2 <= mem2[addr];
    end else if (state == SCRUB_RD) begin
      rd0 <= mem0[scrub_ptr];
      rd1 <= mem1[scrub_ptr];
      rd2 <= mem2[scrub_ptr];
    end
  end

  // Read results, error reporting and latched check address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      rd_valid   <= 1'b0;
      err_single <= 1'b0;
      err_multi  <= 1'b0;
      err_addr   <= '0;
      lat_addr   <= '0;
    end else begin
      rd_valid   <= (state == RD_CHK);
      err_single <= chk && one_off;
      err_multi  <= chk && none_eq;
      if (state == RD_CHK) data_out <= vote;
      if (chk && !all_eq) err_addr <= lat_addr;
      if (user_rd)          lat_addr <= addr;
      else if (scrub_start) lat_addr <= scrub_ptr;
    end
  end

  // Scrub scheduling: a request that collides with the due cycle leaves the
  // scrub pending so it runs on the first later idle cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer     <= '0;
      pend      <= 1'b0;
      scrub_ptr <= '0;
    end else if (SCRUB_EN == 0) begin
      timer     <= '0;
      pend      <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (accept) begin
          timer <= '0;
          if (timer == TMR_LAST) pend <= 1'b1;
        end else if (scrub_start) begin
          timer <= '0;
          pend  <= 1'b0;
        end else begin
          timer <= timer + TMR_W'(1);
        end
      end
      if (state == SCRUB_CHK) scrub_ptr <= scrub_ptr + ADDR_W'(1);
    end
  end

  // Saturating correction counter; clear has priority over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       corr_count <= '0;
    else if (clr_count)                             corr_count <= '0;
    else if ((state == FIX) && (corr_count != '1))  corr_count <= corr_count + CNT_W'(1);
  end

endmodule
